// File: rtl/sd_spi_test_seq.sv
// Multi-sector SD write/read-back self-test sequencer for the SPI SD controller.
// Optional feature macro: SD_TEST_LFSR_EN (per-sector 16-bit Galois LFSR pattern instead of a linear count).
module sd_spi_test_seq #(
  parameter int          DATA_W     = 16,
  parameter int          SEC_WORDS  = 256,
  parameter int          SEC_NUM    = 4,
  parameter logic [31:0] START_ADDR = 32'd2000,
  parameter int          ERR_W      = 16
) (
  input  logic              clk_50m,
  input  logic              reset,
  input  logic              sd_init_done,
  input  logic              wr_busy,
  input  logic              wr_req,
  output logic              wr_start_en,
  output logic [31:0]       wr_sec_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              rd_busy,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_start_en,
  output logic [31:0]       rd_sec_addr,
  output logic              test_done,
  output logic              error_flag,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int CNT_W = $clog2(SEC_WORDS + 1);
  localparam int SEC_W = (SEC_NUM > 1) ? $clog2(SEC_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SEC_WORDS);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_NUM - 1);

  typedef enum logic [2:0] {IDLE, WR_GO, WR_WAIT, RD_GO, RD_WAIT, DONE} state_t;

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a, input logic [1:0] inc);
    logic [ERR_W:0] s;
    s = {1'b0, a} + (ERR_W + 1)'(inc);
    return s[ERR_W] ? {ERR_W{1'b1}} : s[ERR_W-1:0];
  endfunction

`ifdef SD_TEST_LFSR_EN
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic logic [15:0] lfsr_seed(input logic [SEC_W-1:0] s);
    logic [31:0] s32;
    s32 = 32'(s);
    return {s32[7:0], 8'hA5} | 16'h0001;
  endfunction

  if (DATA_W != 16) begin : g_lfsr_width_chk
    $error("SD_TEST_LFSR_EN requires DATA_W == 16");
  end
`else
  function automatic logic [DATA_W-1:0] pattern(input logic [SEC_W-1:0] s, input logic [CNT_W-1:0] w);
    logic [31:0] t;
    t = 32'(s) * 32'(SEC_WORDS) + 32'(w);
    return DATA_W'(t);
  endfunction
`endif

  state_t             state, state_n;
  logic [SEC_W-1:0]   sec, sec_n;
  logic [CNT_W-1:0]   wr_cnt, wr_cnt_n, rd_cnt, rd_cnt_n;
  logic [ERR_W-1:0]   err_n;
  logic               done_n, flag_n, wr_start_n, rd_start_n;
  logic [31:0]        wr_addr_n, rd_addr_n;
  logic               init_s1, init_s2, init_d, wr_busy_d, rd_busy_d;
  logic               start, init_fall, wr_fall, rd_fall, mis, short_sec;
  logic [DATA_W-1:0]  wr_word, rd_exp;

  assign start     = init_s2 & ~init_d;
  assign init_fall = init_d & ~init_s2;
  assign wr_fall   = wr_busy_d & ~wr_busy;
  assign rd_fall   = rd_busy_d & ~rd_busy;

`ifdef SD_TEST_LFSR_EN
  logic [15:0] wr_lfsr, wr_lfsr_n, rd_lfsr, rd_lfsr_n;

  always_ff @(posedge clk_50m) begin
    wr_lfsr <= wr_lfsr_n;
    rd_lfsr <= rd_lfsr_n;
  end

  assign wr_word = DATA_W'(wr_lfsr);
  assign rd_exp  = DATA_W'(rd_lfsr);
`else
  assign wr_word = pattern(sec, wr_cnt);
  assign rd_exp  = pattern(sec, rd_cnt);
`endif

  // Controller samples wr_data in the same cycle it asserts wr_req
  assign wr_data = (state == WR_WAIT) ? wr_word : '0;

  always_comb begin
    state_n   = state;
    sec_n     = sec;
    wr_cnt_n  = wr_cnt;
    rd_cnt_n  = rd_cnt;
    err_n     = err_cnt;
    done_n    = test_done;
    wr_addr_n = wr_sec_addr;
    rd_addr_n = rd_sec_addr;
    mis       = 1'b0;
    short_sec = 1'b0;
`ifdef SD_TEST_LFSR_EN
    wr_lfsr_n = wr_lfsr;
    rd_lfsr_n = rd_lfsr;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = WR_GO;
          sec_n   = '0;
          err_n   = '0;
          done_n  = 1'b0;
        end
      end
      WR_GO: state_n = WR_WAIT;
      WR_WAIT: begin
        if (wr_req) begin
          if (wr_cnt != CNT_MAX) wr_cnt_n = wr_cnt + CNT_W'(1);
`ifdef SD_TEST_LFSR_EN
          wr_lfsr_n = lfsr_step(wr_lfsr);
`endif
        end
        if (wr_fall) begin
          if (sec == SEC_LAST) begin
            state_n = RD_GO;
            sec_n   = '0;
          end else begin
            state_n = WR_GO;
            sec_n   = sec + SEC_W'(1);
          end
        end
      end
      RD_GO: state_n = RD_WAIT;
      RD_WAIT: begin
        if (rd_en) begin
          // Words past the end of the sector are always counted as mismatches
          mis = (rd_cnt == CNT_MAX) || (rd_data != rd_exp);
          if (rd_cnt != CNT_MAX) rd_cnt_n = rd_cnt + CNT_W'(1);
`ifdef SD_TEST_LFSR_EN
          rd_lfsr_n = lfsr_step(rd_lfsr);
`endif
        end
        if (rd_fall) begin
          short_sec = (rd_cnt_n != CNT_MAX);
          if (sec == SEC_LAST) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = RD_GO;
            sec_n   = sec + SEC_W'(1);
          end
        end
        err_n = sat_add(err_cnt, {1'b0, mis} + {1'b0, short_sec});
      end
      default: state_n = IDLE;
    endcase

    if (state_n == WR_GO) begin
      wr_addr_n = START_ADDR + 32'(sec_n);
      wr_cnt_n  = '0;
`ifdef SD_TEST_LFSR_EN
      wr_lfsr_n = lfsr_seed(sec_n);
`endif
    end
    if (state_n == RD_GO) begin
      rd_addr_n = START_ADDR + 32'(sec_n);
      rd_cnt_n  = '0;
`ifdef SD_TEST_LFSR_EN
      rd_lfsr_n = lfsr_seed(sec_n);
`endif
    end

    // Losing SD init aborts everything except a finished result; err_cnt is kept for debug
    if (init_fall && (state != DONE)) begin
      state_n   = IDLE;
      done_n    = 1'b0;
      err_n     = err_cnt;
      wr_addr_n = '0;
      rd_addr_n = '0;
    end

    wr_start_n = (state_n == WR_GO);
    rd_start_n = (state_n == RD_GO);
    flag_n     = ~(done_n && (err_n == '0));
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state       <= IDLE;
      sec         <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      err_cnt     <= '0;
      test_done   <= 1'b0;
      error_flag  <= 1'b1;
      wr_start_en <= 1'b0;
      rd_start_en <= 1'b0;
      wr_sec_addr <= '0;
      rd_sec_addr <= '0;
      init_s1     <= 1'b0;
      init_s2     <= 1'b0;
      init_d      <= 1'b0;
      wr_busy_d   <= 1'b0;
      rd_busy_d   <= 1'b0;
    end else begin
      state       <= state_n;
      sec         <= sec_n;
      wr_cnt      <= wr_cnt_n;
      rd_cnt      <= rd_cnt_n;
      err_cnt     <= err_n;
      test_done   <= done_n;
      error_flag  <= flag_n;
      wr_start_en <= wr_start_n;
      rd_start_en <= rd_start_n;
      wr_sec_addr <= wr_addr_n;
      rd_sec_addr <= rd_addr_n;
      init_s1     <= sd_init_done;
      init_s2     <= init_s1;
      init_d      <= init_s2;
      wr_busy_d   <= wr_busy;
      rd_busy_d   <= rd_busy;
    end
  end

endmodule
